// File: rtl/rtc_bus_reader.sv
// Burst read sequencer for the RTC multiplexed address/data bus.
// Presents each fetched byte with a one-hot load pulse for the holding bank.
module rtc_bus_reader #(
  parameter int         NREG      = 6,
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter int         PHASE_CYC = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [7:0]      AD_IN,
  output logic [7:0]      AD_OUT,
  output logic            AD_OE,
  output logic            CS_N,
  output logic            AS,
  output logic            RD_N,
  output logic [7:0]      DATA_OUT,
  output logic [NREG-1:0] LOAD_EN,
  output logic            BUSY,
  output logic            DONE
);

  localparam int KW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HOLD,
    READ,
    RECOV,
    FIN
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   phase, phase_nx;
  logic [KW-1:0]   k, k_nx;
  logic            phase_end;
  logic            last_reg;
  logic            capture;

  logic [7:0]      ad_out_nx;
  logic            ad_oe_nx;
  logic            cs_n_nx;
  logic            as_nx;
  logic            rd_n_nx;
  logic [7:0]      data_nx;
  logic [NREG-1:0] load_nx;
  logic            busy_nx;
  logic            done_nx;

  assign phase_end = (phase == PW'(PHASE_CYC - 1));
  assign last_reg  = (k == KW'(NREG - 1));
  assign capture   = (state == READ) && phase_end;

  // Sequencer: advance phase counter, step through bus phases per register
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    k_nx     = k;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_nx = ADDR;
          phase_nx = '0;
          k_nx     = '0;
        end
      end
      ADDR: begin
        if (phase_end) begin
          state_nx = HOLD;
          phase_nx = '0;
        end else begin
          phase_nx = phase + PW'(1);
        end
      end
      HOLD: begin
        if (phase_end) begin
          state_nx = READ;
          phase_nx = '0;
        end else begin
          phase_nx = phase + PW'(1);
        end
      end
      READ: begin
        if (phase_end) begin
          state_nx = RECOV;
          phase_nx = '0;
        end else begin
          phase_nx = phase + PW'(1);
        end
      end
      RECOV: begin
        if (phase_end) begin
          phase_nx = '0;
          if (last_reg) begin
            state_nx = FIN;
          end else begin
            state_nx = ADDR;
            k_nx     = k + KW'(1);
          end
        end else begin
          phase_nx = phase + PW'(1);
        end
      end
      FIN: begin
        state_nx = IDLE;
        phase_nx = '0;
        k_nx     = '0;
      end
      default: begin
        state_nx = IDLE;
        phase_nx = '0;
        k_nx     = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every pin comes from a flop
  always_comb begin
    busy_nx   = (state_nx == ADDR) || (state_nx == HOLD) ||
                (state_nx == READ) || (state_nx == RECOV);
    cs_n_nx   = !busy_nx;
    as_nx     = (state_nx == ADDR);
    ad_oe_nx  = (state_nx == ADDR) || (state_nx == HOLD);
    rd_n_nx   = (state_nx != READ);
    done_nx   = (state_nx == FIN);
    ad_out_nx = AD_OUT;
    if (state_nx == ADDR) begin
      ad_out_nx = BASE_ADDR + 8'(k_nx);
    end
    data_nx = DATA_OUT;
    load_nx = '0;
    if (capture) begin
      data_nx = AD_IN;
      load_nx = NREG'(1) << k;
    end
  end

  // State, counters and registered bus/handshake outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      phase    <= '0;
      k        <= '0;
      AD_OUT   <= '0;
      AD_OE    <= 1'b0;
      CS_N     <= 1'b1;
      AS       <= 1'b0;
      RD_N     <= 1'b1;
      DATA_OUT <= '0;
      LOAD_EN  <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      k        <= k_nx;
      AD_OUT   <= ad_out_nx;
      AD_OE    <= ad_oe_nx;
      CS_N     <= cs_n_nx;
      AS       <= as_nx;
      RD_N     <= rd_n_nx;
      DATA_OUT <= data_nx;
      LOAD_EN  <= load_nx;
      BUSY     <= busy_nx;
      DONE     <= done_nx;
    end
  end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed bench for rtc_bus_reader: default burst, address wrap,
// mid-burst reset and single-register fast burst.
module tb_rtc_bus_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instance A: defaults, RTC model attached
  logic       a_start = 1'b0;
  logic [7:0] a_ad_in, a_ad_out, a_data_out;
  logic       a_ad_oe, a_cs_n, a_as, a_rd_n, a_busy, a_done;
  logic [5:0] a_load_en;

  // instance B: wrapping base address
  logic       b_start = 1'b0;
  logic [7:0] b_ad_in, b_ad_out, b_data_out;
  logic       b_ad_oe, b_cs_n, b_as, b_rd_n, b_busy, b_done;
  logic [2:0] b_load_en;

  // instance C: single phase cycle, single register
  logic       c_start = 1'b0;
  logic [7:0] c_ad_in, c_ad_out, c_data_out;
  logic       c_ad_oe, c_cs_n, c_as, c_rd_n, c_busy, c_done;
  logic [0:0] c_load_en;

  rtc_bus_reader u_a (
    .CLK(clk), .RST(rst), .START(a_start), .AD_IN(a_ad_in),
    .AD_OUT(a_ad_out), .AD_OE(a_ad_oe), .CS_N(a_cs_n), .AS(a_as),
    .RD_N(a_rd_n), .DATA_OUT(a_data_out), .LOAD_EN(a_load_en),
    .BUSY(a_busy), .DONE(a_done)
  );

  rtc_bus_reader #(
    .NREG(3), .BASE_ADDR(8'hFE), .PHASE_CYC(4)
  ) u_b (
    .CLK(clk), .RST(rst), .START(b_start), .AD_IN(b_ad_in),
    .AD_OUT(b_ad_out), .AD_OE(b_ad_oe), .CS_N(b_cs_n), .AS(b_as),
    .RD_N(b_rd_n), .DATA_OUT(b_data_out), .LOAD_EN(b_load_en),
    .BUSY(b_busy), .DONE(b_done)
  );

  rtc_bus_reader #(
    .NREG(1), .BASE_ADDR(8'h21), .PHASE_CYC(1)
  ) u_c (
    .CLK(clk), .RST(rst), .START(c_start), .AD_IN(c_ad_in),
    .AD_OUT(c_ad_out), .AD_OE(c_ad_oe), .CS_N(c_cs_n), .AS(c_as),
    .RD_N(c_rd_n), .DATA_OUT(c_data_out), .LOAD_EN(c_load_en),
    .BUSY(c_busy), .DONE(c_done)
  );

  assign b_ad_in = 8'h00;
  assign c_ad_in = 8'h5C;

  // RTC model: latch address on AS falling, return A0 + low nibble
  logic       as_d = 1'b0;
  logic [7:0] lat  = 8'h00;
  always @(negedge clk) begin
    as_d <= a_as;
    if (as_d && !a_as) lat <= a_ad_out;
  end
  assign a_ad_in = 8'hA0 + {4'h0, lat[3:0]};

  task automatic test_reset();
    rst = 1'b1;
    a_start = 1'b1;
    b_start = 1'b1;
    c_start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({a_cs_n, a_as, a_rd_n, a_ad_oe} !== 4'b1010) begin
      n_bad++;
      $display("FAIL reset_strobes got %b want 1010",
               {a_cs_n, a_as, a_rd_n, a_ad_oe});
    end
    n_cmp++;
    if (a_ad_out !== 8'h00 || a_data_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_bytes got %h/%h want 00/00",
               a_ad_out, a_data_out);
    end
    n_cmp++;
    if (a_load_en !== 6'd0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b/%b/%b want 0/0/0",
               a_load_en, a_busy, a_done);
    end
    n_cmp++;
    if (b_busy !== 1'b0 || c_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_other_busy got %b/%b want 0/0",
               b_busy, c_busy);
    end
    rst = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_busy !== 1'b0 || a_cs_n !== 1'b1) begin
        n_bad++;
        $display("FAIL idle_after_reset got busy=%b cs_n=%b want 0/1",
                 a_busy, a_cs_n);
      end
    end
  endtask

  task automatic test_burst(input bit inject);
    int loads;
    int dones;
    int r;
    int j;
    int ph;
    bit ebusy;
    bit edone;
    logic [5:0] eld;
    logic [7:0] ea;
    loads = 0;
    dones = 0;
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      a_start = inject && (cyc == 50 || cyc == 97);
      r = (cyc - 1) % 16;
      j = (cyc - 1) / 16;
      ph = r / 4;
      ebusy = (cyc <= 96);
      edone = (cyc == 97);
      eld = (ebusy && r == 12) ? 6'(1 << j) : 6'd0;
      ea = 8'h21 + 8'(j);
      n_cmp++;
      if (a_busy !== ebusy || a_done !== edone) begin
        n_bad++;
        $display("FAIL burst_busy_done c%0d got %b/%b want %b/%b",
                 cyc, a_busy, a_done, ebusy, edone);
      end
      n_cmp++;
      if (a_cs_n !== !ebusy || a_as !== (ebusy && ph == 0)) begin
        n_bad++;
        $display("FAIL burst_cs_as c%0d got %b/%b want %b/%b",
                 cyc, a_cs_n, a_as, !ebusy, ebusy && ph == 0);
      end
      n_cmp++;
      if (a_rd_n !== !(ebusy && ph == 2) ||
          a_ad_oe !== (ebusy && ph <= 1)) begin
        n_bad++;
        $display("FAIL burst_rd_oe c%0d got %b/%b want %b/%b",
                 cyc, a_rd_n, a_ad_oe, !(ebusy && ph == 2),
                 ebusy && ph <= 1);
      end
      n_cmp++;
      if (a_load_en !== eld) begin
        n_bad++;
        $display("FAIL burst_load_en c%0d got %b want %b",
                 cyc, a_load_en, eld);
      end
      if (ebusy && ph <= 1) begin
        n_cmp++;
        if (a_ad_out !== ea) begin
          n_bad++;
          $display("FAIL burst_ad_out c%0d got %h want %h",
                   cyc, a_ad_out, ea);
        end
      end
      if (eld != 6'd0) begin
        n_cmp++;
        if (a_data_out !== 8'hA1 + 8'(j)) begin
          n_bad++;
          $display("FAIL burst_data c%0d got %h want %h",
                   cyc, a_data_out, 8'hA1 + 8'(j));
        end
      end
      if (a_load_en != 6'd0) loads++;
      if (a_done) dones++;
    end
    n_cmp++;
    if (loads != 6 || dones != 1) begin
      n_bad++;
      $display("FAIL burst_counts got %0d loads %0d done want 6/1",
               loads, dones);
    end
    n_cmp++;
    if (a_data_out !== 8'hA6) begin
      n_bad++;
      $display("FAIL burst_data_hold got %h want a6", a_data_out);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] w [3];
    int dones;
    w[0] = 8'hFE;
    w[1] = 8'hFF;
    w[2] = 8'h00;
    dones = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 52; cyc++) begin
      @(negedge clk);
      b_start = 1'b0;
      if ((cyc - 1) % 16 == 0 && cyc <= 48) begin
        n_cmp++;
        if (b_ad_out !== w[(cyc - 1) / 16] || b_as !== 1'b1) begin
          n_bad++;
          $display("FAIL wrap_addr c%0d got %h as=%b want %h as=1",
                   cyc, b_ad_out, b_as, w[(cyc - 1) / 16]);
        end
      end
      if (b_done) dones++;
      if (cyc == 49) begin
        n_cmp++;
        if (b_done !== 1'b1 || b_busy !== 1'b0) begin
          n_bad++;
          $display("FAIL wrap_done got %b/%b want 1/0", b_done, b_busy);
        end
      end
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL wrap_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid_read();
    int loads;
    int dones;
    loads = 0;
    dones = 0;
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 42; cyc++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (cyc == 42) begin
        n_cmp++;
        if (a_rd_n !== 1'b0 || a_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL midrst_in_read got rd_n=%b busy=%b want 0/1",
                   a_rd_n, a_busy);
        end
        rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (a_cs_n !== 1'b1 || a_rd_n !== 1'b1 || a_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_release got cs_n=%b rd_n=%b busy=%b want 1/1/0",
               a_cs_n, a_rd_n, a_busy);
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (a_load_en != 6'd0) loads++;
      if (a_done) dones++;
    end
    n_cmp++;
    if (loads != 0 || dones != 0 || a_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_quiet got %0d loads %0d done busy=%b want 0/0/0",
               loads, dones, a_busy);
    end
  endtask

  task automatic test_fast_single();
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    c_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      c_start = 1'b0;
      if (c_busy) busy_cnt++;
      n_cmp++;
      if (c_load_en !== 1'(cyc == 4) || c_done !== (cyc == 5)) begin
        n_bad++;
        $display("FAIL fast_load_done c%0d got %b/%b want %b/%b",
                 cyc, c_load_en, c_done, cyc == 4, cyc == 5);
      end
      if (cyc == 4) begin
        n_cmp++;
        if (c_data_out !== 8'h5C) begin
          n_bad++;
          $display("FAIL fast_data got %h want 5c", c_data_out);
        end
      end
    end
    n_cmp++;
    if (busy_cnt != 4) begin
      n_bad++;
      $display("FAIL fast_busy_len got %0d want 4", busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_burst(1'b0);
    test_burst(1'b1);
    test_wrap();
    test_reset_mid_read();
    test_burst(1'b0);
    test_fast_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
